idex_stage: RTL
===============

# idex_stage

ID/EX pipeline register for the RISC-V core. It captures decoded instruction fields from the decode stage and packs them into the 153-bit `idex_reg` bundle. It also produces the registered 4-bit `alu_decode` and the forwarded operand-B value `rdx`, which the EX-stage ALU consumes directly, and it detects load-use hazards, inserting bubbles when one occurs.

## Interface
- `IDEX_W`, 153: width of `idex_reg`. Fixed; the layout depends on it.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: external hold from a downstream stage.
- `flush` in 1: branch/jump redirect; the register loads a bubble.
- `id_valid` in 1: decode stage holds a real instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in 32 each: decode-stage values.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register indices.
- `id_opcode` in 7, `id_funct3` in 3, `id_funct7b5` in 1: instruction fields.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in 32: MEM/WB forwarding source.
- `idex_reg` out 153: packed bundle. The rs1-data field is driven with the forwarded value.
- `alu_decode` out 4: registered ALU operation code.
- `rdx` out 32: ALU operand B (forwarded rs2 or immediate).
- `hazard_stall` out 1: asks upstream to hold IF/ID this cycle.

## Operation
- `idex_reg` layout:
  - [4:0] rd, [9:5] rs1, [14:10] rs2
  - [46:15] imm, [78:47] rs2 data, [110:79] rs1 data, [142:111] pc
  - [143] valid, [144] alu_src, [145] reg_write, [146] mem_read, [147] mem_write, [148] mem_to_reg, [149] branch, [152:150] funct3
- Control generation from the opcode:
  - reg_write: R, I-ALU, load, JAL, JALR, LUI, AUIPC.
  - alu_src: I-ALU, load, store, JALR.
  - mem_read and mem_to_reg: load.
  - mem_write: store.
  - branch: branch, JAL, JALR.
- alu_decode, R-type (0110011), by funct3:
  - 000: SUB=6 if funct7b5, else ADD=2.
  - 001: SLL=3. 010: SLT=4. 011: SLTU=5. 100: XOR=7.
  - 101: SRA=8 if funct7b5, else SRL=9.
  - 110: OR=1. 111: AND=0.
- alu_decode, I-ALU (0010011): same mapping, except 000 is always ADD.
- alu_decode, branch (1100011):
  - BEQ/BNE: 6.
  - BLT/BGE: 4.
  - BLTU/BGEU: 5.
- alu_decode for all other opcodes: ADD=2.
- Bubble: all `idex_reg` bits 0, alu_decode=2.
- Register update priority per edge: reset > flush > stall (hold) > hazard_stall (bubble) > load.
  - On load, valid = id_valid. Control bits are forced to 0 when id_valid=0.
- Forwarding for rs1 and rs2 independently:
  - EX/MEM is used if its reg_write=1, its rd≠0 and its rd equals the registered index.
  - Otherwise MEM/WB is used under the same conditions.
  - Otherwise the registered data is used.
  - EX/MEM wins when both match.
- The forwarded rs1 replaces bits [110:79] on the `idex_reg` output. The stored copy is unchanged.
- `rdx`:
  - alu_src=0: forwarded rs2.
  - alu_src=1 with alu_decode ∈ {3,8,9}: {27'b0, imm[4:0]}.
  - Otherwise: imm.
- `hazard_stall` (combinational) = registered valid & mem_read & rd≠0 & (rd==id_rs1 | rd==id_rs2) & id_valid.

## Timing
- Reset values: `idex_reg`=0, `alu_decode`=2, `hazard_stall`=0, `rdx`=0, one edge after reset is asserted.
- Reset asserted mid-stream clears the register on the next edge, regardless of stall or flush.
- Decode-to-EX latency is one cycle. `rdx`, the rs1 field and `hazard_stall` are combinational from registered state and forwarding inputs, with zero added latency.
- Load-use: one bubble is inserted, and the dependent instruction enters on the following edge with MEM/WB forwarding.
- stall and hazard in the same cycle: the register holds. The hazard persists and resolves after stall deasserts.
- flush and stall in the same cycle: the bubble wins.

## Configuration
- `IDEX_FORWARD_EN` defined: forwarding as described above.
- `IDEX_FORWARD_EN` undefined:
  - `rdx` and the rs1 field use the registered data only.
  - `hazard_stall` asserts for any RAW against this register's rd (reg_write, rd≠0) or against exmem_rd (exmem_reg_write, rd≠0).
  - The register loads bubbles until the hazard clears.

## Test plan
- Reset held 2 cycles, then released → `idex_reg`=0, `alu_decode`=2, `hazard_stall`=0.
- R-type SUB: funct3=000, funct7b5=1, rs1_data=10, rs2_data=3 → next cycle `alu_decode`=6, `rdx`=3, bits [110:79]=10.
- SRAI with imm=0x40000405 → `alu_decode`=8, `rdx`=5.
- Forwarding: registered rs2=x5, exmem_rd=5 with result 0xAAAA, memwb_rd=5 with result 0xBBBB → `rdx`=0xAAAA. With exmem_reg_write=0 → `rdx`=0xBBBB. With rd=x0 → registered data.
- Load-use: LW x7 in this register, decode holds ADD x8,x7,x1 → `hazard_stall`=1 for one cycle, then a bubble (valid=0), then the ADD with rs1 field = memwb_result.
- stall held 3 cycles → `idex_reg` constant. flush together with stall → bubble on the next edge.

Source files
------------

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with control decode, operand forwarding and load-use hazard detection.
// Latency: one cycle decode-to-EX; rdx, the rs1 field and hazard_stall are combinational from registered state.
// Backpressure: stall holds the register, hazard_stall holds IF/ID and loads a bubble, flush beats stall.
// Define IDEX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding; otherwise hazards stall until the writer retires.
module idex_stage #(
  parameter int IDEX_W = 153
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [31:0]       exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [31:0]       memwb_result,
  output logic [IDEX_W-1:0] idex_reg,
  output logic [3:0]        alu_decode,
  output logic [31:0]       rdx,
  output logic              hazard_stall
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;

  typedef struct packed {
    logic [2:0]  funct3;
    logic        branch;
    logic        mem_to_reg;
    logic        mem_write;
    logic        mem_read;
    logic        reg_write;
    logic        alu_src;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_dat;
    logic [31:0] rs2_dat;
    logic [31:0] imm;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
  } idex_t;

  idex_t       idex_q, idex_d, idex_out;
  logic [3:0]  alu_q, alu_d;
  logic        ctl_rw, ctl_as, ctl_mr, ctl_mw, ctl_br;
  logic [31:0] rs1_fwd, rs2_fwd;
  logic        q_rd_match;

  always_comb begin
    ctl_rw = 1'b0;
    ctl_as = 1'b0;
    ctl_mr = 1'b0;
    ctl_mw = 1'b0;
    ctl_br = 1'b0;
    case (id_opcode)
      OP_R:      ctl_rw = 1'b1;
      OP_I:      begin ctl_rw = 1'b1; ctl_as = 1'b1; end
      OP_LOAD:   begin ctl_rw = 1'b1; ctl_as = 1'b1; ctl_mr = 1'b1; end
      OP_STORE:  begin ctl_as = 1'b1; ctl_mw = 1'b1; end
      OP_BRANCH: ctl_br = 1'b1;
      OP_JAL:    begin ctl_rw = 1'b1; ctl_br = 1'b1; end
      OP_JALR:   begin ctl_rw = 1'b1; ctl_as = 1'b1; ctl_br = 1'b1; end
      OP_LUI,
      OP_AUIPC:  ctl_rw = 1'b1;
      default:   ctl_rw = 1'b0;
    endcase
  end

  always_comb begin
    alu_d = ALU_ADD;
    if (id_opcode == OP_R || id_opcode == OP_I) begin
      case (id_funct3)
        3'b000:  alu_d = (id_opcode == OP_R && id_funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_d = ALU_SLL;
        3'b010:  alu_d = ALU_SLT;
        3'b011:  alu_d = ALU_SLTU;
        3'b100:  alu_d = ALU_XOR;
        3'b101:  alu_d = id_funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_d = ALU_OR;
        default: alu_d = ALU_AND;
      endcase
    end else if (id_opcode == OP_BRANCH) begin
      case (id_funct3)
        3'b000, 3'b001: alu_d = ALU_SUB;
        3'b100, 3'b101: alu_d = ALU_SLT;
        3'b110, 3'b111: alu_d = ALU_SLTU;
        default:        alu_d = ALU_ADD;
      endcase
    end
  end

  // Control bits of a non-instruction must never reach EX, whatever the opcode bits say.
  always_comb begin
    idex_d            = '0;
    idex_d.funct3     = id_funct3;
    idex_d.branch     = ctl_br & id_valid;
    idex_d.mem_to_reg = ctl_mr & id_valid;
    idex_d.mem_write  = ctl_mw & id_valid;
    idex_d.mem_read   = ctl_mr & id_valid;
    idex_d.reg_write  = ctl_rw & id_valid;
    idex_d.alu_src    = ctl_as & id_valid;
    idex_d.valid      = id_valid;
    idex_d.pc         = id_pc;
    idex_d.rs1_dat    = id_rs1_data;
    idex_d.rs2_dat    = id_rs2_data;
    idex_d.imm        = id_imm;
    idex_d.rs2        = id_rs2;
    idex_d.rs1        = id_rs1;
    idex_d.rd         = id_rd;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      idex_q <= '0;
      alu_q  <= ALU_ADD;
    end else if (!stall) begin
      if (hazard_stall) begin
        idex_q <= '0;
        alu_q  <= ALU_ADD;
      end else begin
        idex_q <= idex_d;
        alu_q  <= alu_d;
      end
    end
  end

  always_comb begin
    rs1_fwd = idex_q.rs1_dat;
    rs2_fwd = idex_q.rs2_dat;
`ifdef IDEX_FORWARD_EN
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_q.rs1)
      rs1_fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_q.rs1)
      rs1_fwd = memwb_result;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_q.rs2)
      rs2_fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_q.rs2)
      rs2_fwd = memwb_result;
`endif
  end

  assign q_rd_match = (idex_q.rd != 5'd0) && ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));

`ifdef IDEX_FORWARD_EN
  assign hazard_stall = idex_q.valid & idex_q.mem_read & q_rd_match & id_valid;
`else
  // Without forwarding any pending writer in EX or MEM blocks a dependent reader.
  logic ex_rd_match;
  logic unused_fwd_inputs;
  assign ex_rd_match = exmem_reg_write && (exmem_rd != 5'd0) &&
                       ((exmem_rd == id_rs1) || (exmem_rd == id_rs2));
  assign hazard_stall = id_valid & ((idex_q.reg_write & q_rd_match) | ex_rd_match);
  assign unused_fwd_inputs = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result};
`endif

  always_comb begin
    idex_out         = idex_q;
    idex_out.rs1_dat = rs1_fwd;
  end

  // Shift-immediate ops only consume shamt, so the upper immediate bits are masked.
  always_comb begin
    if (!idex_q.alu_src)
      rdx = rs2_fwd;
    else if (alu_q == ALU_SLL || alu_q == ALU_SRA || alu_q == ALU_SRL)
      rdx = {27'd0, idex_q.imm[4:0]};
    else
      rdx = idex_q.imm;
  end

  assign idex_reg   = idex_out;
  assign alu_decode = alu_q;

endmodule
